// File: rtl/dice_pkg.sv
// Shared constants and state encoding for the dice roll engine.
package dice_pkg;

  localparam logic [2:0] FACE_MIN   = 3'd1;
  localparam logic [2:0] FACE_MAX   = 3'd6;
  localparam logic [2:0] FACE_BLANK = 3'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SHOW    = 2'd2
  } dice_state_t;

  // 1..6 successor; 6 wraps to 1 by explicit compare so 7 and 0 never appear
  function automatic logic [2:0] next_face(input logic [2:0] f);
    return (f == FACE_MAX) ? FACE_MIN : f + 3'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, counting debouncer and 0->1 edge pulse for a raw button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;

endmodule

// File: rtl/dice_roll_controller.sv
// Dice roll engine: debounced press starts a timed tumble that settles on a
// face sampled from a free-running 1..6 counter.
module dice_roll_controller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_CYCLES     = 2500000,
  parameter int ROLL_STEPS      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_btn,
  output logic [2:0] number,
  output logic       rolling,
  output logic       result_valid
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int STEP_W = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROLL_STEPS - 1);

  dice_state_t       r_state, w_state_nxt;
  logic [2:0]        r_face_ctr;
  logic [TICK_W-1:0] r_tick_ctr, w_tick_nxt;
  logic [STEP_W-1:0] r_step_ctr, w_step_nxt;
  logic [2:0]        r_number, w_number_nxt;
  logic              r_rolling, w_rolling_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_btn_level;
  logic              w_btn_rise;
  logic              w_press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (roll_btn),
    .btn_level(w_btn_level),
    .btn_rise (w_btn_rise)
  );

  assign w_press = w_btn_rise && w_btn_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_face_ctr <= FACE_MIN;
    else        r_face_ctr <= next_face(r_face_ctr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tick_ctr <= '0;
      r_step_ctr <= '0;
      r_number   <= FACE_BLANK;
      r_rolling  <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_ctr <= w_tick_nxt;
      r_step_ctr <= w_step_nxt;
      r_number   <= w_number_nxt;
      r_rolling  <= w_rolling_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // Presses are only honoured in IDLE and SHOW; ROLLING ignores them, including on its final tick
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_ctr;
    w_step_nxt    = r_step_ctr;
    w_number_nxt  = r_number;
    w_rolling_nxt = r_rolling;
    w_valid_nxt   = r_valid;
    case (r_state)
      IDLE, SHOW: begin
        if (w_press) begin
          w_state_nxt   = ROLLING;
          w_number_nxt  = r_face_ctr;
          w_tick_nxt    = '0;
          w_step_nxt    = '0;
          w_rolling_nxt = 1'b1;
          w_valid_nxt   = 1'b0;
        end
      end
      ROLLING: begin
        if (r_tick_ctr == TICK_LAST) begin
          w_tick_nxt = '0;
          w_step_nxt = r_step_ctr + 1'b1;
          if (r_step_ctr == STEP_LAST) begin
            w_number_nxt  = r_face_ctr;
            w_rolling_nxt = 1'b0;
            w_valid_nxt   = 1'b1;
            w_state_nxt   = SHOW;
          end else begin
            w_number_nxt = next_face(r_number);
          end
        end else begin
          w_tick_nxt = r_tick_ctr + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_number_nxt  = FACE_BLANK;
        w_rolling_nxt = 1'b0;
        w_valid_nxt   = 1'b0;
      end
    endcase
  end

  assign number       = r_number;
  assign rolling      = r_rolling;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Self-checking bench for dice_roll_controller with short debounce/tick/step settings.
module tb_dice_roll_controller;
  import dice_pkg::*;

  localparam int DEB       = 4;
  localparam int TICK      = 3;
  localparam int STEPS     = 5;
  localparam int ROLL_CLKS = TICK * STEPS;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       roll_btn = 1'b0;
  logic [2:0] number;
  logic       rolling;
  logic       result_valid;

  int n_pass    = 0;
  int n_total   = 0;
  int range_bad = 0;
  int excl_bad  = 0;
  int rise_cnt  = 0;

  logic [2:0] m_face;
  logic [2:0] last_result;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  dice_roll_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK),
    .ROLL_STEPS     (STEPS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .roll_btn    (roll_btn),
    .number      (number),
    .rolling     (rolling),
    .result_valid(result_valid)
  );

  function automatic logic [2:0] adv(input logic [2:0] f);
    return (f == 3'd6) ? 3'd1 : f + 3'd1;
  endfunction

  // Reference free-running face counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_face <= 3'd1;
    else        m_face <= adv(m_face);
  end

  // Sampled at posedge, i.e. the values settled during the previous cycle
  always @(posedge clk) begin
    if (number > 3'd6) range_bad++;
    if (rolling && result_valid) excl_bad++;
    if (dut.u_debouncer.btn_rise) rise_cnt++;
  end

  task automatic enter_roll(output logic [2:0] start);
    start = m_face;
    @(negedge clk);
    n_total++;
    if ({dut.r_state, rolling, result_valid, number} !== {ROLLING, 1'b1, 1'b0, start})
      $display("FAIL roll_entry got state=%0d rolling=%b valid=%b number=%0d want state=%0d rolling=1 valid=0 number=%0d",
               dut.r_state, rolling, result_valid, number, ROLLING, start);
    else n_pass++;
  endtask

  task automatic press_and_enter(output logic [2:0] start, output bit ok);
    int waited = 0;
    start = 3'd0;
    while (dut.u_debouncer.btn_rise !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    ok = (dut.u_debouncer.btn_rise === 1'b1);
    if (!ok) begin
      n_total++;
      $display("FAIL press_timeout got no press after %0d clks want press", waited);
    end else begin
      enter_roll(start);
    end
  endtask

  task automatic follow_roll(input logic [2:0] start, input bit extra_press);
    logic [2:0] e;
    logic [2:0] want;
    e = start;
    for (int i = 1; i <= ROLL_CLKS; i++) begin
      if (extra_press && i == 1) roll_btn = 1'b0;
      if (extra_press && i == 7) roll_btn = 1'b1;
      if (i == ROLL_CLKS) exp_q.push_back(m_face);
      @(negedge clk);
      if (i < ROLL_CLKS) begin
        if (i % TICK == 0) e = adv(e);
        n_total++;
        if ({dut.r_state, rolling, result_valid, number} !== {ROLLING, 1'b1, 1'b0, e})
          $display("FAIL roll_step i=%0d got state=%0d rolling=%b valid=%b number=%0d want number=%0d",
                   i, dut.r_state, rolling, result_valid, number, e);
        else n_pass++;
      end else begin
        want = exp_q.pop_front();
        last_result = want;
        n_total++;
        if ({dut.r_state, rolling, result_valid, number} !== {SHOW, 1'b0, 1'b1, want})
          $display("FAIL roll_land got state=%0d rolling=%b valid=%b number=%0d want state=%0d rolling=0 valid=1 number=%0d",
                   dut.r_state, rolling, result_valid, number, SHOW, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] ef;
    rst_n = 1'b0;
    roll_btn = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({dut.r_state, number, rolling, result_valid, dut.r_face_ctr} !== {IDLE, 3'd0, 1'b0, 1'b0, 3'd1})
      $display("FAIL reset_hold got state=%0d number=%0d rolling=%b valid=%b face=%0d want 0/0/0/0/1",
               dut.r_state, number, rolling, result_valid, dut.r_face_ctr);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ef = 3'((k % 6) + 1);
      n_total++;
      if ({number, rolling, result_valid, dut.r_face_ctr} !== {3'd0, 1'b0, 1'b0, ef})
        $display("FAIL reset_idle k=%0d got number=%0d rolling=%b valid=%b face=%0d want 0/0/0 face=%0d",
                 k, number, rolling, result_valid, dut.r_face_ctr, ef);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int r0 = rise_cnt;
    roll_btn = 1'b1;
    repeat (3) @(negedge clk);
    roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if ({rise_cnt - r0, dut.r_state, number} !== {32'd0, IDLE, 3'd0})
      $display("FAIL glitch_ignored got presses=%0d state=%0d number=%0d want 0/%0d/0",
               rise_cnt - r0, dut.r_state, number, IDLE);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    logic [2:0] start;
    roll_btn = 1'b1;
    for (int k = 1; k <= 2 + DEB; k++) begin
      @(negedge clk);
      n_total++;
      if (dut.u_debouncer.btn_rise !== (k == 2 + DEB))
        $display("FAIL press_latency k=%0d got rise=%b want %b", k, dut.u_debouncer.btn_rise, (k == 2 + DEB));
      else n_pass++;
    end
    enter_roll(start);
    follow_roll(start, 1'b0);
    repeat (5) @(negedge clk);
    n_total++;
    if ({dut.r_state, rolling, result_valid, number} !== {SHOW, 1'b0, 1'b1, last_result})
      $display("FAIL show_hold got state=%0d rolling=%b valid=%b number=%0d want number=%0d",
               dut.r_state, rolling, result_valid, number, last_result);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [2:0] start;
    bit ok;
    int r0;
    roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if ({dut.r_state, result_valid, number} !== {SHOW, 1'b1, last_result})
      $display("FAIL release_ignored got state=%0d valid=%b number=%0d want number=%0d",
               dut.r_state, result_valid, number, last_result);
    else n_pass++;
    r0 = rise_cnt;
    roll_btn = 1'b1; @(negedge clk);
    roll_btn = 1'b0; @(negedge clk);
    roll_btn = 1'b1; @(negedge clk);
    roll_btn = 1'b0; @(negedge clk);
    roll_btn = 1'b1;
    press_and_enter(start, ok);
    if (ok) follow_roll(start, 1'b1);
    repeat (4) @(negedge clk);
    n_total++;
    if ({rise_cnt - r0, dut.r_state, number} !== {32'd2, SHOW, last_result})
      $display("FAIL bounce_single_roll got presses=%0d state=%0d number=%0d want 2/%0d/%0d",
               rise_cnt - r0, dut.r_state, number, SHOW, last_result);
    else n_pass++;
  endtask

  task automatic test_show_press();
    logic [2:0] start;
    bit ok;
    roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if (result_valid !== 1'b1)
      $display("FAIL show_before_press got valid=%b want 1", result_valid);
    else n_pass++;
    roll_btn = 1'b1;
    press_and_enter(start, ok);
    if (ok) follow_roll(start, 1'b0);
  endtask

  task automatic test_reset_mid_roll();
    logic [2:0] start;
    bit ok;
    roll_btn = 1'b0;
    repeat (10) @(negedge clk);
    roll_btn = 1'b1;
    press_and_enter(start, ok);
    repeat (2 * TICK + 1) @(negedge clk);
    n_total++;
    if ({dut.r_state, dut.r_step_ctr} !== {ROLLING, 3'd2})
      $display("FAIL mid_roll_pos got state=%0d step=%0d want %0d/2", dut.r_state, dut.r_step_ctr, ROLLING);
    else n_pass++;
    rst_n = 1'b0;
    roll_btn = 1'b0;
    #1;
    n_total++;
    if ({dut.r_state, number, rolling, result_valid} !== {IDLE, 3'd0, 1'b0, 1'b0})
      $display("FAIL async_reset got state=%0d number=%0d rolling=%b valid=%b want all 0",
               dut.r_state, number, rolling, result_valid);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({dut.r_state, number, rolling, result_valid} !== {IDLE, 3'd0, 1'b0, 1'b0})
      $display("FAIL after_reset got state=%0d number=%0d rolling=%b valid=%b want all 0",
               dut.r_state, number, rolling, result_valid);
    else n_pass++;
    roll_btn = 1'b1;
    press_and_enter(start, ok);
    if (ok) follow_roll(start, 1'b0);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_bounce();
    test_show_press();
    test_reset_mid_roll();
    roll_btn = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (range_bad !== 0) $display("FAIL number_range got %0d bad cycles want 0", range_bad);
    else n_pass++;
    n_total++;
    if (excl_bad !== 0) $display("FAIL rolling_valid_exclusive got %0d bad cycles want 0", excl_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
